// File: rtl/padd_arb_pkg.sv
// Shared types for the point-add engine arbiter.
// State encoding and operand slot positions.
package padd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FLT   = 3'd4
  } arb_state_e;

  // Slot k of a 5*N operand bus occupies [(k+1)*N-1 : k*N].
  localparam int unsigned OP_P1_X = 4;
  localparam int unsigned OP_P1_Z = 3;
  localparam int unsigned OP_P2_X = 2;
  localparam int unsigned OP_P2_Z = 1;
  localparam int unsigned OP_PX   = 0;
  localparam int unsigned NUM_OPS = 5;

endpackage

// File: rtl/padd_share_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Pointer moves only when the grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  // Tie goes to the side that did not win last.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last_q : req[1];
    last_d    = accept ? gnt_id : last_q;
  end

  // Last-grant pointer; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/padd_share_arbiter.sv
// Shares one point-add engine between two requesters.
// One issue per grant, watchdog on the engine reply.
module padd_share_arbiter
  import padd_arb_pkg::*;
#(
  parameter int N       = 233,
  parameter int TO_W    = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           REQ0,
  input  logic           REQ1,
  input  logic [5*N-1:0] R0_OPS,
  input  logic [5*N-1:0] R1_OPS,
  output logic           DONE0,
  output logic           DONE1,
  output logic [N-1:0]   DOUT_X,
  output logic [N-1:0]   DOUT_Z,
  output logic           BUSY,
  output logic           FAULT,
  input  logic           FAULT_CLR,
  output logic           ENG_IN_VALID,
  output logic [5*N-1:0] ENG_OPS,
  input  logic           ENG_OUT_VALID,
  input  logic [N-1:0]   ENG_DOUT_X,
  input  logic [N-1:0]   ENG_DOUT_Z
);

  localparam logic [TO_W-1:0] TMAX =
    TO_W'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic            gid_q, gid_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [5*N-1:0]  ops_q, ops_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    z_q, z_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic            inv_q, inv_d;

  logic gnt_valid;
  logic gnt_id;
  logic accept;

  rr_arb2 u_rr (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req       ({REQ1, REQ0}),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    x_d     = x_q;
    z_d     = z_q;
    fault_d = fault_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    inv_d   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          accept  = 1'b1;
          gid_d   = gnt_id;
          ops_d   = gnt_id ? R1_OPS : R0_OPS;
          inv_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        if (ENG_OUT_VALID) begin
          x_d     = ENG_DOUT_X;
          z_d     = ENG_DOUT_Z;
          done0_d = ~gid_q;
          done1_d = gid_q;
          state_d = DONE;
        end else if (cnt_q == TMAX) begin
          fault_d = 1'b1;
          state_d = FLT;
        end
      end
      DONE: state_d = IDLE;
      FLT: begin
        if (FAULT_CLR) begin
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
      x_q     <= '0;
      z_q     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      x_q     <= x_d;
      z_q     <= z_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      inv_q   <= inv_d;
    end
  end

  assign DONE0        = done0_q;
  assign DONE1        = done1_q;
  assign DOUT_X       = x_q;
  assign DOUT_Z       = z_q;
  assign BUSY         = busy_q;
  assign FAULT        = fault_q;
  assign ENG_IN_VALID = inv_q;
  assign ENG_OPS      = ops_q;

endmodule

// File: tb/tb_padd_share_arbiter.sv
// Bench for padd_share_arbiter: vector table,
// engine stub and a service scoreboard.
module tb_padd_share_arbiter;

  localparam int N    = 233;
  localparam int W    = 5 * N;
  localparam int TOUT = 16;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         REQ0 = 1'b0;
  logic         REQ1 = 1'b0;
  logic         FAULT_CLR = 1'b0;
  logic         ENG_OUT_VALID = 1'b0;
  logic [W-1:0] R0_OPS = '0;
  logic [W-1:0] R1_OPS = '0;
  logic [N-1:0] ENG_DOUT_X = '0;
  logic [N-1:0] ENG_DOUT_Z = '0;
  logic [W-1:0] ENG_OPS;
  logic [N-1:0] DOUT_X, DOUT_Z;
  logic         DONE0, DONE1, BUSY, FAULT;
  logic         ENG_IN_VALID;

  padd_share_arbiter #(
    .N(N), .TO_W(12), .TIMEOUT(TOUT)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .REQ0          (REQ0),
    .REQ1          (REQ1),
    .R0_OPS        (R0_OPS),
    .R1_OPS        (R1_OPS),
    .DONE0         (DONE0),
    .DONE1         (DONE1),
    .DOUT_X        (DOUT_X),
    .DOUT_Z        (DOUT_Z),
    .BUSY          (BUSY),
    .FAULT         (FAULT),
    .FAULT_CLR     (FAULT_CLR),
    .ENG_IN_VALID  (ENG_IN_VALID),
    .ENG_OPS       (ENG_OPS),
    .ENG_OUT_VALID (ENG_OUT_VALID),
    .ENG_DOUT_X    (ENG_DOUT_X),
    .ENG_DOUT_Z    (ENG_DOUT_Z)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit           id;
    logic [W-1:0] ops;
    logic [N-1:0] x;
    logic [N-1:0] z;
    int           lat;
    int           exp_in;
    int           exp_done;
  } sb_t;

  typedef struct {
    bit       rst;
    bit [1:0] req;
    int       lat0;
    int       lat1;
    bit       first;
  } vec_t;

  sb_t          sb[$];
  vec_t         vt[7];
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc;
  int           t_next;
  logic [N-1:0] last_x, last_z;

  function automatic logic [N-1:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[N-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_ops();
    logic [W-1:0] o;
    for (int k = 0; k < 5; k++) o[k*N +: N] = rnd();
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm,
                      input int act,
                      input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ops(input string nm,
                         input logic [W-1:0] exp);
    for (int s = 0; s < 5; s++)
      chk($sformatf("%s[%0d]", nm, s),
          ENG_OPS[s*N +: N], exp[s*N +: N]);
  endtask

  // Expected service: id, operands, reply, timing.
  task automatic push(input bit id, input int lat);
    sb_t e;
    e.id       = id;
    e.ops      = id ? R1_OPS : R0_OPS;
    e.x        = rnd();
    e.z        = rnd();
    e.lat      = lat;
    e.exp_in   = t_next;
    e.exp_done = t_next + 1 + lat;
    t_next     = e.exp_done + 2;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Engine stub plus monitor; drains the scoreboard.
  task automatic run(input int max_cyc, input bit hold1);
    sb_t e;
    int  ecnt;
    bit  rearm0;
    ecnt   = -1;
    rearm0 = 1'b0;
    for (int k = 0; k < max_cyc && sb.size() > 0; k++) begin
      @(negedge CLK);
      cyc++;
      ENG_OUT_VALID = 1'b0;
      if (rearm0) begin
        REQ0   = 1'b1;
        rearm0 = 1'b0;
      end
      if (ENG_IN_VALID) begin
        chki("in_cycle", cyc, sb[0].exp_in);
        chki("busy_issue", int'(BUSY), 1);
        chk_ops("eng_ops", sb[0].ops);
        ecnt = sb[0].lat;
      end else if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin
          ENG_OUT_VALID = 1'b1;
          ENG_DOUT_X    = sb[0].x;
          ENG_DOUT_Z    = sb[0].z;
          ecnt          = -1;
        end
      end
      if (DONE0 || DONE1) begin
        e = sb.pop_front();
        chki("done_vec", int'({DONE1, DONE0}), e.id ? 2 : 1);
        chki("done_cycle", cyc, e.exp_done);
        chk("dout_x", DOUT_X, e.x);
        chk("dout_z", DOUT_Z, e.z);
        chki("fault_at_done", int'(FAULT), 0);
        last_x = e.x;
        last_z = e.z;
        if (e.id) begin
          if (!hold1) REQ1 = 1'b0;
        end else begin
          REQ0 = 1'b0;
          if (hold1) rearm0 = 1'b1;
        end
      end
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_timeout: %0d pending, want 0",
               sb.size());
      sb.delete();
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim stuck, want finish");
    $fatal(1);
  end

  initial begin
    int in_at, flt_at;
    bit saw_done;

    vt[0] = '{rst:1'b0, req:2'b01, lat0:5, lat1:0, first:1'b0};
    vt[1] = '{rst:1'b1, req:2'b11, lat0:3, lat1:4, first:1'b0};
    vt[2] = '{rst:1'b0, req:2'b11, lat0:2, lat1:6, first:1'b0};
    vt[3] = '{rst:1'b0, req:2'b10, lat0:0, lat1:1, first:1'b1};
    vt[4] = '{rst:1'b0, req:2'b11, lat0:2, lat1:2, first:1'b0};
    vt[5] = '{rst:1'b0, req:2'b01, lat0:7, lat1:0, first:1'b0};
    vt[6] = '{rst:1'b0, req:2'b11, lat0:1, lat1:3, first:1'b1};

    repeat (3) @(negedge CLK);
    chki("rst_done", int'({DONE1, DONE0}), 0);
    chk("rst_dout_x", DOUT_X, '0);
    chk("rst_dout_z", DOUT_Z, '0);
    chki("rst_busy", int'(BUSY), 0);
    chki("rst_fault", int'(FAULT), 0);
    chki("rst_in_valid", int'(ENG_IN_VALID), 0);
    chk_ops("rst_eng_ops", '0);
    RST_N = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vt[v].rst) reset_dut();
      @(negedge CLK);
      R0_OPS = rnd_ops();
      R1_OPS = rnd_ops();
      REQ0   = vt[v].req[0];
      REQ1   = vt[v].req[1];
      cyc    = 0;
      t_next = 1;
      push(vt[v].first,
           vt[v].first ? vt[v].lat1 : vt[v].lat0);
      if (vt[v].req == 2'b11)
        push(~vt[v].first,
             vt[v].first ? vt[v].lat0 : vt[v].lat1);
      run(200, 1'b0);
    end

    // Engine strobe in IDLE must not disturb the result.
    @(negedge CLK);
    ENG_OUT_VALID = 1'b1;
    ENG_DOUT_X    = rnd();
    ENG_DOUT_Z    = rnd();
    @(negedge CLK);
    ENG_OUT_VALID = 1'b0;
    chk("idle_strobe_x", DOUT_X, last_x);
    chk("idle_strobe_z", DOUT_Z, last_z);
    chki("idle_strobe_done", int'({DONE1, DONE0}), 0);
    chki("idle_strobe_busy", int'(BUSY), 0);

    // REQ1 held, REQ0 re-raised after each service.
    @(negedge CLK);
    R0_OPS = rnd_ops();
    R1_OPS = rnd_ops();
    REQ0   = 1'b1;
    REQ1   = 1'b1;
    cyc    = 0;
    t_next = 1;
    push(1'b1, 3);
    push(1'b0, 2);
    push(1'b1, 4);
    push(1'b0, 1);
    run(300, 1'b1);

    // Reply on the last allowed WAIT cycle; clear is ignored.
    @(negedge CLK);
    FAULT_CLR = 1'b1;
    R0_OPS    = rnd_ops();
    REQ0      = 1'b1;
    cyc       = 0;
    t_next    = 1;
    push(1'b0, TOUT);
    run(100, 1'b0);
    FAULT_CLR = 1'b0;

    // Silent engine: watchdog fault, clear, re-grant.
    @(negedge CLK);
    R1_OPS   = rnd_ops();
    REQ1     = 1'b1;
    cyc      = 0;
    in_at    = -1;
    flt_at   = -1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      cyc++;
      if (ENG_IN_VALID && in_at < 0) in_at = cyc;
      if (FAULT && flt_at < 0) flt_at = cyc;
      if (DONE0 || DONE1) saw_done = 1'b1;
    end
    chki("flt_in_cycle", in_at, 1);
    chki("flt_fault_cycle", flt_at, 2 + TOUT);
    chki("flt_no_done", int'(saw_done), 0);
    chki("flt_busy", int'(BUSY), 1);
    chki("flt_fault_held", int'(FAULT), 1);
    chk_ops("flt_eng_ops", R1_OPS);
    FAULT_CLR = 1'b1;
    @(negedge CLK);
    FAULT_CLR = 1'b0;
    chki("clr_fault", int'(FAULT), 0);
    chki("clr_busy", int'(BUSY), 0);
    cyc    = 0;
    t_next = 1;
    push(1'b1, 2);
    run(100, 1'b0);

    // Async reset while waiting on the engine.
    @(negedge CLK);
    R0_OPS = rnd_ops();
    REQ0   = 1'b1;
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chki("arst_done", int'({DONE1, DONE0}), 0);
    chk("arst_dout_x", DOUT_X, '0);
    chk("arst_dout_z", DOUT_Z, '0);
    chki("arst_busy", int'(BUSY), 0);
    chki("arst_fault", int'(FAULT), 0);
    chki("arst_in_valid", int'(ENG_IN_VALID), 0);
    chk_ops("arst_eng_ops", '0);
    REQ0 = 1'b0;
    @(negedge CLK);
    RST_N         = 1'b1;
    ENG_OUT_VALID = 1'b1;
    ENG_DOUT_X    = rnd();
    ENG_DOUT_Z    = rnd();
    @(negedge CLK);
    ENG_OUT_VALID = 1'b0;
    chk("post_rst_strobe_x", DOUT_X, '0);
    chki("post_rst_done", int'({DONE1, DONE0}), 0);
    chki("post_rst_busy", int'(BUSY), 0);
    R0_OPS = rnd_ops();
    REQ0   = 1'b1;
    cyc    = 0;
    t_next = 1;
    push(1'b0, 3);
    run(100, 1'b0);

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
